// File: rtl/bpsk_bit_framer.sv
// bpsk_bit_framer
// Builds BPSK frames from payload bytes: alternating preamble, sync word,
// then payload MSB first, at BIT_PERIOD clocks per bit. Between frames the
// output idles at 1 so the modulator emits unmodulated carrier.
module bpsk_bit_framer #(
  parameter int unsigned BIT_PERIOD   = 16,
  parameter int unsigned PREAMBLE_LEN = 16,
  parameter logic [7:0]  SYNC_WORD    = 8'hD3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic       data_bit,
  output logic       bit_strobe,
  output logic       busy,
  output logic       underrun
);

  localparam int unsigned BW = $clog2(BIT_PERIOD);
  localparam int unsigned PW = $clog2(PREAMBLE_LEN + 1);

  localparam logic [BW-1:0] BIT_LAST = BW'(BIT_PERIOD - 1);
  localparam logic [PW-1:0] PRE_LAST = PW'(PREAMBLE_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PREAMBLE,
    ST_SYNC,
    ST_PAYLOAD
  } state_t;

  // Registered state
  state_t        state_q;
  logic [BW-1:0] bit_cnt_q;
  logic [PW-1:0] pre_cnt_q;
  logic [2:0]    bit_idx_q;
  logic [7:0]    shreg_q;
  logic          cur_last_q;
  logic [7:0]    buf_data_q;
  logic          buf_last_q;
  logic          buf_full_q;
  logic          last_seen_q;

  // Next-state values
  state_t        state_d;
  logic [BW-1:0] bit_cnt_d;
  logic [PW-1:0] pre_cnt_d;
  logic [2:0]    bit_idx_d;
  logic [7:0]    shreg_d;
  logic          cur_last_d;
  logic [7:0]    buf_data_d;
  logic          buf_last_d;
  logic          buf_full_d;
  logic          last_seen_d;
  logic          data_bit_d;
  logic          bit_strobe_d;
  logic          busy_d;
  logic          underrun_d;
  logic          in_ready_d;

  logic accept;
  logic bit_end;

  assign accept  = in_valid && in_ready;
  assign bit_end = (bit_cnt_q == BIT_LAST);

  // Next-state, buffer handshake and registered-output values
  always_comb begin
    logic drain;
    logic to_idle;

    // NOTE: every variable assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d      = state_q;
    bit_cnt_d    = bit_end ? '0 : bit_cnt_q + 1'b1;
    pre_cnt_d    = pre_cnt_q;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    cur_last_d   = cur_last_q;
    buf_data_d   = buf_data_q;
    buf_last_d   = buf_last_q;
    buf_full_d   = buf_full_q;
    last_seen_d  = last_seen_q;
    data_bit_d   = data_bit;
    bit_strobe_d = 1'b0;
    busy_d       = busy;
    underrun_d   = 1'b0;
    drain        = 1'b0;
    to_idle      = 1'b0;

    // Buffer write; in_ready is low whenever the buffer is full, so a write
    // never lands in the same cycle as a drain.
    if (accept) begin
      buf_data_d = in_data;
      buf_last_d = in_last;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        data_bit_d = 1'b1;
        busy_d     = 1'b0;
        bit_cnt_d  = '0;
        // A byte left in the buffer (accepted on the clock an underrun
        // ended the previous frame) starts the next frame as well.
        if (accept || buf_full_q) begin
          state_d      = ST_PREAMBLE;
          pre_cnt_d    = '0;
          bit_strobe_d = 1'b1;
          data_bit_d   = 1'b1;
          busy_d       = 1'b1;
        end
      end

      ST_PREAMBLE: begin
        if (bit_end) begin
          bit_strobe_d = 1'b1;
          if (pre_cnt_q == PRE_LAST) begin
            state_d    = ST_SYNC;
            bit_idx_d  = 3'd7;
            data_bit_d = SYNC_WORD[7];
          end else begin
            pre_cnt_d  = pre_cnt_q + 1'b1;
            // Bit i+1 is ~(i+1)[0], which equals i[0].
            data_bit_d = pre_cnt_q[0];
          end
        end
      end

      ST_SYNC: begin
        if (bit_end) begin
          bit_strobe_d = 1'b1;
          if (bit_idx_q == 3'd0) begin
            state_d    = ST_PAYLOAD;
            shreg_d    = buf_data_q;
            cur_last_d = buf_last_q;
            bit_idx_d  = 3'd7;
            data_bit_d = buf_data_q[7];
            drain      = 1'b1;
          end else begin
            bit_idx_d  = bit_idx_q - 3'd1;
            data_bit_d = SYNC_WORD[bit_idx_d];
          end
        end
      end

      ST_PAYLOAD: begin
        if (bit_end) begin
          if (bit_idx_q != 3'd0) begin
            bit_strobe_d = 1'b1;
            bit_idx_d    = bit_idx_q - 3'd1;
            shreg_d      = {shreg_q[6:0], 1'b0};
            data_bit_d   = shreg_q[6];
          end else if (cur_last_q) begin
            to_idle = 1'b1;
          end else if (buf_full_q) begin
            bit_strobe_d = 1'b1;
            shreg_d      = buf_data_q;
            cur_last_d   = buf_last_q;
            bit_idx_d    = 3'd7;
            data_bit_d   = buf_data_q[7];
            drain        = 1'b1;
          end else begin
            underrun_d = 1'b1;
            to_idle    = 1'b1;
          end
        end
      end

      default: begin
        to_idle = 1'b1;
      end
    endcase

    if (drain) begin
      buf_full_d = 1'b0;
    end

    if (to_idle) begin
      state_d     = ST_IDLE;
      data_bit_d  = 1'b1;
      busy_d      = 1'b0;
      last_seen_d = 1'b0;
    end

    if (accept && in_last) begin
      last_seen_d = 1'b1;
    end

    in_ready_d = !buf_full_d && !last_seen_d;
  end

  // State, storage and output registers
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values computed above.
    if (!rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      bit_idx_q   <= '0;
      // NOTE: the shift register and holding buffer are cleared as well; a
      // reset mid-frame must leave no stale byte or flag to restart from.
      shreg_q     <= '0;
      cur_last_q  <= 1'b0;
      buf_data_q  <= '0;
      buf_last_q  <= 1'b0;
      buf_full_q  <= 1'b0;
      last_seen_q <= 1'b0;
      data_bit    <= 1'b1;
      bit_strobe  <= 1'b0;
      busy        <= 1'b0;
      underrun    <= 1'b0;
      in_ready    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      cur_last_q  <= cur_last_d;
      buf_data_q  <= buf_data_d;
      buf_last_q  <= buf_last_d;
      buf_full_q  <= buf_full_d;
      last_seen_q <= last_seen_d;
      data_bit    <= data_bit_d;
      bit_strobe  <= bit_strobe_d;
      busy        <= busy_d;
      underrun    <= underrun_d;
      in_ready    <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_bpsk_bit_framer.sv
// Directed testbench for bpsk_bit_framer (BIT_PERIOD=4, PREAMBLE_LEN=8,
// SYNC_WORD=8'hD3). Outputs are sampled on the falling clock edge.
module tb_bpsk_bit_framer;

  localparam int         BP = 4;
  localparam int         PL = 8;
  localparam logic [7:0] SW = 8'hD3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       data_bit;
  logic       bit_strobe;
  logic       busy;
  logic       underrun;

  int total = 0;
  int bad   = 0;

  bit         pending  = 1'b0;  // handshake completes at the coming edge
  bit         last_acc = 1'b0;  // frame's last byte has been accepted
  logic [8:0] src[$];           // {last, data} bytes still to offer
  logic       exp_bits[$];

  bpsk_bit_framer #(
    .BIT_PERIOD  (BP),
    .PREAMBLE_LEN(PL),
    .SYNC_WORD   (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .data_bit  (data_bit),
    .bit_strobe(bit_strobe),
    .busy      (busy),
    .underrun  (underrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_inputs();
    if (src.size() > 0) begin
      in_valid = 1'b1;
      in_last  = src[0][8];
      in_data  = src[0][7:0];
    end else begin
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = 8'h00;
    end
  endtask

  // Advance to the next falling edge; retire a byte the last rising edge took.
  task automatic tick(output bit acc);
    @(negedge clk);
    acc = pending;
    if (pending) begin
      if (src[0][8]) last_acc = 1'b1;
      void'(src.pop_front());
      load_inputs();
    end
    pending = in_valid && in_ready;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data_bit"}, data_bit, 1'b1);
    check({tag, "_strobe"}, bit_strobe, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_underrun"}, underrun, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b0);
  endtask

  // Wait (bounded) for the frame to start, then check every clock of it
  // against the expected bit sequence, and the first IDLE clock after it.
  task automatic run_frame(input string tag, input int n_bytes, input bit exp_underrun,
                           input int max_wait);
    bit acc;
    int waited;
    int nclk;
    exp_bits.delete();
    for (int i = 0; i < PL; i++) exp_bits.push_back((i % 2) == 0);
    for (int k = 7; k >= 0; k--) exp_bits.push_back(SW[k]);
    for (int b = 0; b < n_bytes; b++)
      for (int k = 7; k >= 0; k--) exp_bits.push_back(src[b][k]);
    nclk = exp_bits.size() * BP;

    acc = 1'b0;
    waited = 0;
    while (!acc) begin
      tick(acc);
      if (!acc) begin
        check({tag, "_pre_start_busy"}, busy, 1'b0);
        waited++;
        if (waited >= max_wait) begin
          check({tag, "_start_timeout_busy"}, busy, 1'b1);
          return;
        end
      end
    end

    for (int j = 0; j < nclk; j++) begin
      if (j > 0) tick(acc);
      check($sformatf("%s_bit%0d_data", tag, j / BP), data_bit, exp_bits[j / BP]);
      check($sformatf("%s_clk%0d_strobe", tag, j), bit_strobe, (j % BP) == 0);
      check($sformatf("%s_clk%0d_busy", tag, j), busy, 1'b1);
      check($sformatf("%s_clk%0d_underrun", tag, j), underrun, 1'b0);
      if (last_acc) check($sformatf("%s_clk%0d_in_ready", tag, j), in_ready, 1'b0);
    end

    tick(acc);
    check({tag, "_end_busy"}, busy, 1'b0);
    check({tag, "_end_data_bit"}, data_bit, 1'b1);
    check({tag, "_end_strobe"}, bit_strobe, 1'b0);
    check({tag, "_end_underrun"}, underrun, exp_underrun);
    check({tag, "_end_in_ready"}, in_ready, 1'b1);
    last_acc = 1'b0;
  endtask

  initial begin
    bit acc;

    // Reset state and in_ready rising on the first clock after release
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    check("release_in_ready_low", in_ready, 1'b0);
    tick(acc);
    check("release_in_ready_high", in_ready, 1'b1);

    // Idle with no stimulus
    for (int i = 0; i < 1000; i++) begin
      tick(acc);
      check("idle_data_bit", data_bit, 1'b1);
      check("idle_busy", busy, 1'b0);
      check("idle_strobe", bit_strobe, 1'b0);
      check("idle_in_ready", in_ready, 1'b1);
    end

    // Single-byte frame: 10101010 11010011 10100101
    src.push_back({1'b1, 8'hA5});
    load_inputs();
    pending = in_valid && in_ready;
    run_frame("single", 1, 1'b0, 2);

    // Three-byte frame with in_valid held high
    src.push_back({1'b0, 8'h00});
    src.push_back({1'b0, 8'hFF});
    src.push_back({1'b1, 8'h3C});
    load_inputs();
    pending = in_valid && in_ready;
    run_frame("three", 3, 1'b0, 2);

    // Underrun: one byte without last, then nothing
    src.push_back({1'b0, 8'h81});
    load_inputs();
    pending = in_valid && in_ready;
    run_frame("underrun", 1, 1'b1, 2);
    tick(acc);
    check("underrun_one_shot", underrun, 1'b0);
    check("underrun_after_busy", busy, 1'b0);

    // Back-to-back: frame 2's byte waits during frame 1, then starts after
    // exactly one IDLE clock
    src.push_back({1'b1, 8'h5A});
    src.push_back({1'b1, 8'hC3});
    load_inputs();
    pending = in_valid && in_ready;
    run_frame("b2b_first", 1, 1'b0, 2);
    run_frame("b2b_second", 1, 1'b0, 1);

    // Reset asserted during SYNC
    src.push_back({1'b1, 8'h6E});
    load_inputs();
    pending = in_valid && in_ready;
    tick(acc);
    check("rstmid_started", busy, 1'b1);
    for (int j = 0; j < 40; j++) tick(acc);
    check("rstmid_in_sync_busy", busy, 1'b1);
    check("rstmid_in_sync_bit", data_bit, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("rstmid_async");
    src.delete();
    pending  = 1'b0;
    last_acc = 1'b0;
    load_inputs();
    repeat (2) @(negedge clk);
    check_reset_outputs("rstmid_held");
    rst = 1'b1;

    // Clean 1-byte frame after release
    src.push_back({1'b1, 8'h96});
    load_inputs();
    pending = in_valid && in_ready;
    run_frame("restart", 1, 1'b0, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
